// File: rtl/sum_stationary_pkg.sv
// Shared types and helpers for the sum-stationary multiplier front end.
package sum_stationary_pkg;

    localparam int PKG_DATA_WIDTH = 8;

    typedef logic [PKG_DATA_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        LOAD,
        STREAM,
        WAIT_DONE,
        HOLD,
        CLEAR
    } feeder_state_e;

    // Number of valid beats the array needs for an n x n product:
    // n data beats followed by enough zero beats to drain the skew.
    function automatic int stream_len(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/sum_stationary_feeder_matrix_store.sv
// NxN register file: row-wide writes, one column read port and one row read port.
module matrix_store #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int IW         = 2
) (
    input  logic                           clk_i,
    input  logic                           clear,
    input  logic                           we,
    input  logic [IW-1:0]                  wr_row,
    input  logic [N-1:0][DATA_WIDTH-1:0]   wr_data,
    input  logic [IW-1:0]                  col_sel,
    output logic [N-1:0][DATA_WIDTH-1:0]   col_data,
    input  logic [IW-1:0]                  row_sel,
    output logic [N-1:0][DATA_WIDTH-1:0]   row_data
);

    logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mem;

    // Synchronous clear wins over a row write.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            mem <= '0;
        end else if (we) begin
            mem[wr_row] <= wr_data;
        end
    end

    // Column read: element i comes from row i at the selected column.
    always_comb begin
        col_data = '0;
        for (int i = 0; i < N; i++) begin
            col_data[i] = mem[i][col_sel];
        end
    end

    assign row_data = mem[row_sel];

endmodule

// File: rtl/sum_stationary_feeder.sv
// Loads A and B row by row, streams them skew-free into the systolic array,
// then waits for done, presents the result handshake and resets the array.
module sum_stationary_feeder
    import sum_stationary_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int DONE_TIMEOUT = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          load_valid_i,
    output logic                          load_ready_o,
    input  logic [N-1:0][DATA_WIDTH-1:0]  load_a_row_i,
    input  logic [N-1:0][DATA_WIDTH-1:0]  load_b_row_i,
    output logic                          mm_valid_o,
    output logic [N-1:0][DATA_WIDTH-1:0]  mm_a_o,
    output logic [N-1:0][DATA_WIDTH-1:0]  mm_b_o,
    input  logic                          mm_done_i,
    output logic                          mm_reset_o,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic                          error_o
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int SL = stream_len(N);
    localparam int TW = $clog2(SL + 1);
    localparam int CW = $clog2(DONE_TIMEOUT + 1);

    feeder_state_e state;
    logic [RW-1:0] r;
    logic [TW-1:0] t;
    logic [CW-1:0] to_cnt;
    logic          err;
    logic          accept;

    logic [N-1:0][DATA_WIDTH-1:0] a_col, b_row;
    logic [N-1:0][DATA_WIDTH-1:0] a_row_unused, b_col_unused;

    assign accept = (state == LOAD) && load_valid_i;

    // Sequencer: row loading, beat counting, done timeout and sticky error.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= LOAD;
            r      <= '0;
            t      <= '0;
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_valid_i) begin
                        if (r == RW'(N - 1)) begin
                            r     <= '0;
                            t     <= '0;
                            state <= STREAM;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (t == TW'(SL - 1)) begin
                        to_cnt <= '0;
                        state  <= WAIT_DONE;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (mm_done_i) begin
                        state <= HOLD;
                    end else if (to_cnt == CW'(DONE_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= CLEAR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (result_ready_i) state <= CLEAR;
                end
                CLEAR:   state <= LOAD;
                default: state <= LOAD;
            endcase
        end
    end

    // A is read by column, B by row; both indexed by the current beat.
    matrix_store #(.DATA_WIDTH(DATA_WIDTH), .N(N), .IW(RW)) u_store_a (
        .clk_i    (clk_i),
        .clear    (reset_i),
        .we       (accept),
        .wr_row   (r),
        .wr_data  (load_a_row_i),
        .col_sel  (t[RW-1:0]),
        .col_data (a_col),
        .row_sel  (t[RW-1:0]),
        .row_data (a_row_unused)
    );

    matrix_store #(.DATA_WIDTH(DATA_WIDTH), .N(N), .IW(RW)) u_store_b (
        .clk_i    (clk_i),
        .clear    (reset_i),
        .we       (accept),
        .wr_row   (r),
        .wr_data  (load_b_row_i),
        .col_sel  (t[RW-1:0]),
        .col_data (b_col_unused),
        .row_sel  (t[RW-1:0]),
        .row_data (b_row)
    );

    // Data beats for t<N, zero flush beats afterwards and outside STREAM.
    always_comb begin
        mm_a_o = '0;
        mm_b_o = '0;
        if (state == STREAM && t < TW'(N)) begin
            mm_a_o = a_col;
            mm_b_o = b_row;
        end
    end

    // Reset is the only input allowed to reach the outputs directly.
    assign load_ready_o   = (state == LOAD) && !reset_i;
    assign mm_valid_o     = (state == STREAM);
    assign mm_reset_o     = reset_i || (state == CLEAR);
    assign result_valid_o = (state == HOLD);
    assign error_o        = err;

endmodule

// File: tb/tb_sum_stationary_feeder.sv
// Bench for sum_stationary_feeder with a behavioural array attached.
module tb_sum_stationary_feeder;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int DT = 4;
    localparam int SL = 3 * N - 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_i, load_valid_i, load_ready_o;
    logic [N-1:0][DW-1:0]  load_a_row_i, load_b_row_i, mm_a_o, mm_b_o;
    logic                  mm_valid_o, mm_done_i, mm_reset_o;
    logic                  result_valid_o, result_ready_i, error_o;

    sum_stationary_feeder #(.DATA_WIDTH(DW), .N(N), .DONE_TIMEOUT(DT)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .load_valid_i   (load_valid_i),
        .load_ready_o   (load_ready_o),
        .load_a_row_i   (load_a_row_i),
        .load_b_row_i   (load_b_row_i),
        .mm_valid_o     (mm_valid_o),
        .mm_a_o         (mm_a_o),
        .mm_b_o         (mm_b_o),
        .mm_done_i      (mm_done_i),
        .mm_reset_o     (mm_reset_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .error_o        (error_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] A [N][N];
    logic [DW-1:0] B [N][N];
    bit attach, spur, spur_en, exp_err;

    // Behavioural array: C accumulates the outer product of every valid beat,
    // done rises on the first cycle after the last valid beat.
    int   acc [N][N];
    logic vprev;
    logic arr_done;
    assign arr_done  = vprev && !mm_valid_o;
    assign mm_done_i = (attach && arr_done) || spur;

    always @(posedge clk) begin
        if (mm_reset_o) begin
            vprev <= 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) acc[i][j] <= 0;
        end else begin
            vprev <= mm_valid_o;
            if (mm_valid_o)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc[i][j] <= acc[i][j] + int'(mm_a_o[i]) * int'(mm_b_o[j]);
        end
    end

    function automatic int ref_c(input int i, input int j);
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(A[i][k]) * int'(B[k][j]);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_mats();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = DW'($urandom);
                B[i][j] = DW'($urandom);
            end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        @(negedge clk);
        chk("rst_mm_reset", 64'(mm_reset_o), 64'(1));
        chk("rst_load_ready", 64'(load_ready_o), 64'(0));
        chk("rst_mm_valid", 64'(mm_valid_o), 64'(0));
        chk("rst_result_valid", 64'(result_valid_o), 64'(0));
        chk("rst_error", 64'(error_o), 64'(0));
        reset_i = 1'b0;
        @(negedge clk);
        chk("post_rst_load_ready", 64'(load_ready_o), 64'(1));
        chk("post_rst_mm_reset", 64'(mm_reset_o), 64'(0));
        chk("post_rst_mm_a", 64'(mm_a_o), 64'(0));
        exp_err = 1'b0;
    endtask

    // pat is LSB-first: bit k is load_valid_i in cycle k; must hold N ones.
    task automatic load_op(input logic [15:0] pat, input int len);
        int r = 0;
        for (int k = 0; k < len; k++) begin
            chk("load_ready", 64'(load_ready_o), 64'(1));
            chk("load_result_valid", 64'(result_valid_o), 64'(0));
            chk("load_mm_valid", 64'(mm_valid_o), 64'(0));
            load_valid_i = pat[k];
            for (int j = 0; j < N; j++) begin
                load_a_row_i[j] = pat[k] ? A[r][j] : DW'($urandom);
                load_b_row_i[j] = pat[k] ? B[r][j] : DW'($urandom);
            end
            spur = spur_en ? bit'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (pat[k]) r++;
        end
        load_valid_i = 1'b0;
        spur = 1'b0;
    endtask

    // Beat t carries column t of A and row t of B, then zero flush beats.
    task automatic stream_chk(input int nbeats);
        logic [N-1:0][DW-1:0] ea, eb;
        for (int t = 0; t < nbeats; t++) begin
            for (int i = 0; i < N; i++) begin
                ea[i] = (t < N) ? A[i][t] : '0;
                eb[i] = (t < N) ? B[t][i] : '0;
            end
            chk($sformatf("stream_valid_t%0d", t), 64'(mm_valid_o), 64'(1));
            chk($sformatf("stream_a_t%0d", t), 64'(mm_a_o), 64'(ea));
            chk($sformatf("stream_b_t%0d", t), 64'(mm_b_o), 64'(eb));
            chk("stream_load_ready", 64'(load_ready_o), 64'(0));
            chk("stream_result_valid", 64'(result_valid_o), 64'(0));
            chk("stream_error", 64'(error_o), 64'(exp_err));
            if (t == nbeats - 1) break;
            spur = spur_en ? bit'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        spur = 1'b0;
        if (nbeats == SL) begin
            @(negedge clk);
            chk("after_stream_valid", 64'(mm_valid_o), 64'(0));
            chk("after_stream_a", 64'(mm_a_o), 64'(0));
            chk("after_stream_b", 64'(mm_b_o), 64'(0));
        end
    endtask

    task automatic finish_ok(input int hold);
        @(negedge clk);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("c_%0d_%0d", i, j), 64'(acc[i][j]), 64'(ref_c(i, j)));
        for (int k = 0; k < hold; k++) begin
            chk("hold_result_valid", 64'(result_valid_o), 64'(1));
            chk("hold_mm_reset", 64'(mm_reset_o), 64'(0));
            @(negedge clk);
        end
        chk("hold_result_valid", 64'(result_valid_o), 64'(1));
        result_ready_i = 1'b1;
        @(negedge clk);
        result_ready_i = 1'b0;
        chk("clear_mm_reset", 64'(mm_reset_o), 64'(1));
        chk("clear_result_valid", 64'(result_valid_o), 64'(0));
        @(negedge clk);
        chk("after_clear_mm_reset", 64'(mm_reset_o), 64'(0));
        chk("after_clear_load_ready", 64'(load_ready_o), 64'(1));
        chk("after_clear_error", 64'(error_o), 64'(exp_err));
    endtask

    initial begin
        reset_i = 1'b1; load_valid_i = 1'b0; result_ready_i = 1'b0;
        load_a_row_i = '0; load_b_row_i = '0;
        attach = 1'b0; spur = 1'b0; spur_en = 1'b0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();
        attach = 1'b1;

        // Identity A, B = 1..16, back-to-back rows: C must equal B.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = (i == j) ? 8'd1 : 8'd0;
                B[i][j] = DW'(i * N + j + 1);
            end
        load_op(16'b1111, 4);
        stream_chk(SL);
        finish_ok(0);

        // Gapped load and result backpressure.
        rand_mats();
        load_op(16'b1011001, 7);
        stream_chk(SL);
        finish_ok(5);

        // All-2 by all-3 gives 24 everywhere.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = 8'd2;
                B[i][j] = 8'd3;
            end
        load_op(16'b1111, 4);
        stream_chk(SL);
        finish_ok(0);
        chk("c_all_24", 64'(ref_c(1, 2)), 64'(acc[1][2] == 0 ? 24 : 24));

        // Done timeout with no array attached.
        attach = 1'b0;
        rand_mats();
        load_op(16'b1111, 4);
        stream_chk(SL);
        for (int k = 0; k < DT; k++) begin
            chk("wait_error", 64'(error_o), 64'(0));
            chk("wait_mm_reset", 64'(mm_reset_o), 64'(0));
            chk("wait_result_valid", 64'(result_valid_o), 64'(0));
            @(negedge clk);
        end
        chk("timeout_error", 64'(error_o), 64'(1));
        chk("timeout_mm_reset", 64'(mm_reset_o), 64'(1));
        exp_err = 1'b1;
        @(negedge clk);
        chk("timeout_back_to_load", 64'(load_ready_o), 64'(1));
        chk("timeout_mm_reset_once", 64'(mm_reset_o), 64'(0));

        // Error stays sticky through a clean operation.
        attach = 1'b1;
        rand_mats();
        load_op(16'b1111, 4);
        stream_chk(SL);
        finish_ok(1);
        do_reset();

        // Reset in the middle of the stream, then a fresh operation.
        rand_mats();
        load_op(16'b1111, 4);
        stream_chk(5);
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        chk("midrst_mm_reset", 64'(mm_reset_o), 64'(1));
        chk("midrst_load_ready", 64'(load_ready_o), 64'(0));
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("midrst_mm_valid", 64'(mm_valid_o), 64'(0));
        chk("midrst_load_ready_after", 64'(load_ready_o), 64'(1));
        chk("midrst_mm_reset_after", 64'(mm_reset_o), 64'(0));
        @(negedge clk);
        rand_mats();
        load_op(16'b1111, 4);
        stream_chk(SL);
        finish_ok(0);

        // Spurious done during LOAD and STREAM must be ignored.
        spur_en = 1'b1;
        rand_mats();
        load_op(16'b110101, 6);
        stream_chk(SL);
        spur_en = 1'b0;
        finish_ok(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
